// File: rtl/mem_stage_access_ctrl_if.sv
// Bundle between EXE, the MEM-stage access controller, the data memory and WB.
// master = the controller; slave = its environment (EXE, data memory, WB sink).
interface mem_stage_access_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              ex_valid;
  logic              ex_read;
  logic              ex_write;
  logic              ex_memtoreg;
  logic [DATA_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic [4:0]        ex_rd;
  logic              stall;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_rd;
  logic              wb_memtoreg;
  logic              err;

  modport master (
    input  ex_valid, ex_read, ex_write, ex_memtoreg, ex_addr, ex_wdata, ex_rd,
    input  mem_ack, mem_rdata,
    output stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_data, wb_rd, wb_memtoreg, err
  );

  modport slave (
    output ex_valid, ex_read, ex_write, ex_memtoreg, ex_addr, ex_wdata, ex_rd,
    output mem_ack, mem_rdata,
    input  stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_data, wb_rd, wb_memtoreg, err
  );
endinterface

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage load/store sequencer: one req/ack memory transaction per access, ALU ops retire in 1 cycle.
// Loads/stores occupy >=2 cycles; stall (combinational) holds EXE until ack or timeout.
module mem_stage_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_stage_access_ctrl_if.master bus
);
  localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  state_e            state_q,       state_d;
  logic [CNT_W-1:0]  cnt_q,         cnt_d;
  logic              mem_req_q,     mem_req_d;
  logic              mem_we_q,      mem_we_d;
  logic [DATA_W-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
  logic [4:0]        rd_q,          rd_d;
  logic              memtoreg_q,    memtoreg_d;
  logic              wb_valid_q,    wb_valid_d;
  logic [DATA_W-1:0] wb_data_q,     wb_data_d;
  logic [4:0]        wb_rd_q,       wb_rd_d;
  logic              wb_memtoreg_q, wb_memtoreg_d;
  logic              err_q,         err_d;

  logic acc;
  logic bad;
  logic is_mem_op;
  logic misaligned;
  logic tmo_hit;

  always_comb begin
    is_mem_op  = bus.ex_read | bus.ex_write;
    misaligned = bus.ex_addr[1:0] != 2'b00;
    acc        = bus.ex_valid & (bus.ex_read ^ bus.ex_write);
    bad        = bus.ex_valid & ((bus.ex_read & bus.ex_write) | (is_mem_op & misaligned));
    tmo_hit    = cnt_q == CNT_LAST;
  end

  // Reset gating keeps stall quiet while the pipeline is being flushed.
  assign bus.stall = ~rst & (((state_q == ST_IDLE) & acc & ~bad) |
                             ((state_q == ST_WAIT) & ~bus.mem_ack & ~tmo_hit));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rd_d          = rd_q;
    memtoreg_d    = memtoreg_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    wb_memtoreg_d = wb_memtoreg_q;
    err_d         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bad) begin
          err_d = 1'b1;
        end else if (acc) begin
          state_d     = ST_WAIT;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.ex_write;
          mem_addr_d  = bus.ex_addr;
          mem_wdata_d = bus.ex_wdata;
          rd_d        = bus.ex_rd;
          memtoreg_d  = bus.ex_memtoreg;
        end else if (bus.ex_valid) begin
          wb_valid_d    = 1'b1;
          wb_data_d     = bus.ex_addr;
          wb_rd_d       = bus.ex_rd;
          wb_memtoreg_d = 1'b0;
        end
      end

      ST_WAIT: begin
        if (bus.mem_ack) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // Stores retire silently; only loads produce a writeback.
          if (!mem_we_q) begin
            wb_valid_d    = 1'b1;
            wb_data_d     = bus.mem_rdata;
            wb_rd_d       = rd_q;
            wb_memtoreg_d = memtoreg_q;
          end
        end else if (tmo_hit) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_q          <= '0;
      memtoreg_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_memtoreg_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_q          <= rd_d;
      memtoreg_q    <= memtoreg_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      err_q         <= err_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_memtoreg = wb_memtoreg_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Bench for mem_stage_access_ctrl: directed instruction sequence, a transaction-level
// reference model compared every cycle, and literal expectations per scenario.
module tb_mem_stage_access_ctrl;
  localparam int DATA_W  = 32;
  localparam int TMO_CYC = 16;

  logic clk;
  logic rst;

  mem_stage_access_ctrl_if #(.DATA_W(DATA_W)) bus ();

  mem_stage_access_ctrl #(.DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction record plus the expected registered outputs.
  bit          m_busy;
  int          m_waited;
  bit          m_is_wr;
  logic [4:0]  m_rd;
  bit          m_mtr;
  logic        e_req, e_we, e_wbv, e_err, e_mtr;
  logic [31:0] e_addr, e_wdata, e_wbd;
  logic [4:0]  e_wbrd;

  always @(posedge clk) begin
    e_wbv = 1'b0;
    e_err = 1'b0;
    if (rst) begin
      m_busy = 0; m_waited = 0;
      e_req = 1'b0; e_we = 1'b0;
    end else if (m_busy) begin
      if (bus.mem_ack) begin
        m_busy = 0; e_req = 1'b0; e_we = 1'b0;
        if (!m_is_wr) begin
          e_wbv = 1'b1; e_wbd = bus.mem_rdata; e_wbrd = m_rd; e_mtr = m_mtr;
        end
      end else if (m_waited == TMO_CYC - 1) begin
        m_busy = 0; e_req = 1'b0; e_we = 1'b0; e_err = 1'b1;
      end else begin
        m_waited++;
      end
    end else if (bus.ex_valid) begin
      if ((bus.ex_read && bus.ex_write) ||
          ((bus.ex_read || bus.ex_write) && (bus.ex_addr % 4 != 0))) begin
        e_err = 1'b1;
      end else if (bus.ex_read || bus.ex_write) begin
        m_busy = 1; m_waited = 0; m_is_wr = bus.ex_write;
        m_rd = bus.ex_rd; m_mtr = bus.ex_memtoreg;
        e_req = 1'b1; e_we = bus.ex_write; e_addr = bus.ex_addr; e_wdata = bus.ex_wdata;
      end else begin
        e_wbv = 1'b1; e_wbd = bus.ex_addr; e_wbrd = bus.ex_rd; e_mtr = 1'b0;
      end
    end
  end

  // Per-cycle compare and event counters, sampled mid-cycle.
  bit mon_en = 0;
  int stall_cnt = 0, req_cnt = 0, we_cnt = 0, wbv_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic st_exp;
      st_exp = !rst && ((!m_busy && bus.ex_valid && (bus.ex_read != bus.ex_write) &&
                         (bus.ex_addr % 4 == 0)) ||
                        (m_busy && !bus.mem_ack && m_waited != TMO_CYC - 1));
      chk("model.stall",    32'(bus.stall),    32'(st_exp));
      chk("model.mem_req",  32'(bus.mem_req),  32'(e_req));
      chk("model.wb_valid", 32'(bus.wb_valid), 32'(e_wbv));
      chk("model.err",      32'(bus.err),      32'(e_err));
      if (e_req) begin
        chk("model.mem_we",    32'(bus.mem_we), 32'(e_we));
        chk("model.mem_addr",  bus.mem_addr,    e_addr);
        chk("model.mem_wdata", bus.mem_wdata,   e_wdata);
      end
      if (e_wbv) begin
        chk("model.wb_data",     bus.wb_data,          e_wbd);
        chk("model.wb_rd",       32'(bus.wb_rd),       32'(e_wbrd));
        chk("model.wb_memtoreg", 32'(bus.wb_memtoreg), 32'(e_mtr));
      end
      if (bus.stall)               stall_cnt++;
      if (bus.mem_req)             req_cnt++;
      if (bus.mem_req && bus.mem_we) we_cnt++;
      if (bus.wb_valid)            wbv_cnt++;
      if (bus.err)                 err_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit rd_en, input bit wr_en, input bit mtr,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    bus.ex_valid = v; bus.ex_read = rd_en; bus.ex_write = wr_en; bus.ex_memtoreg = mtr;
    bus.ex_addr = addr; bus.ex_wdata = wdata; bus.ex_rd = rd;
  endtask

  task automatic idle_ex();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
  endtask

  int s0, r0, w0, v0, e0;

  task automatic snap();
    s0 = stall_cnt; r0 = req_cnt; w0 = we_cnt; v0 = wbv_cnt; e0 = err_cnt;
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    drive(1, 0, 0, 0, 32'h1234, 32'h0, 5'd5);

    // 1. reset with an ALU op held valid, then it retires
    step(2);
    mon_en = 1;
    @(negedge clk);
    chk("rst.stall",       32'(bus.stall),       0);
    chk("rst.mem_req",     32'(bus.mem_req),     0);
    chk("rst.mem_we",      32'(bus.mem_we),      0);
    chk("rst.mem_addr",    bus.mem_addr,         0);
    chk("rst.mem_wdata",   bus.mem_wdata,        0);
    chk("rst.wb_valid",    32'(bus.wb_valid),    0);
    chk("rst.wb_data",     bus.wb_data,          0);
    chk("rst.wb_rd",       32'(bus.wb_rd),       0);
    chk("rst.wb_memtoreg", 32'(bus.wb_memtoreg), 0);
    chk("rst.err",         32'(bus.err),         0);
    rst = 1'b0;
    step(1);
    idle_ex();
    @(negedge clk);
    chk("alu.wb_valid", 32'(bus.wb_valid), 1);
    chk("alu.wb_data",  bus.wb_data,       32'h1234);
    chk("alu.wb_rd",    32'(bus.wb_rd),    5);
    step(1);

    // 2. load, ack on the fourth WAIT cycle
    snap();
    drive(1, 1, 0, 1, 32'h100, 32'h0, 5'd3);
    step(4);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    step(1);
    bus.mem_ack = 1'b0; idle_ex();
    @(negedge clk);
    chk("load.wb_valid",    32'(bus.wb_valid),    1);
    chk("load.wb_data",     bus.wb_data,          32'hDEADBEEF);
    chk("load.wb_rd",       32'(bus.wb_rd),       3);
    chk("load.wb_memtoreg", 32'(bus.wb_memtoreg), 1);
    chk("load.stall_cycles", 32'(stall_cnt - s0), 4);
    chk("load.req_cycles",   32'(req_cnt - r0),   4);
    step(1);

    // 3. store, ack in the first WAIT cycle
    snap();
    drive(1, 0, 1, 0, 32'h200, 32'hA5A5A5A5, 5'd0);
    step(1);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("store.mem_we",    32'(bus.mem_we), 1);
    chk("store.mem_addr",  bus.mem_addr,    32'h200);
    chk("store.mem_wdata", bus.mem_wdata,   32'hA5A5A5A5);
    step(1);
    bus.mem_ack = 1'b0; idle_ex();
    step(2);
    chk("store.we_cycles",    32'(we_cnt - w0),    1);
    chk("store.stall_cycles", 32'(stall_cnt - s0), 1);
    chk("store.wb_pulses",    32'(wbv_cnt - v0),   0);

    // 4. misaligned load, then read+write together
    snap();
    drive(1, 1, 0, 1, 32'h102, 32'h0, 5'd4);
    @(negedge clk);
    chk("misal.stall", 32'(bus.stall), 0);
    step(1);
    idle_ex();
    @(negedge clk);
    chk("misal.err",     32'(bus.err),     1);
    chk("misal.mem_req", 32'(bus.mem_req), 0);
    step(1);
    drive(1, 1, 1, 0, 32'h300, 32'h0, 5'd6);
    @(negedge clk);
    chk("rw.stall", 32'(bus.stall), 0);
    step(1);
    idle_ex();
    @(negedge clk);
    chk("rw.err",      32'(bus.err),      1);
    chk("rw.wb_valid", 32'(bus.wb_valid), 0);
    step(1);
    chk("err.req_cycles", 32'(req_cnt - r0), 0);
    chk("err.pulses",     32'(err_cnt - e0), 2);

    // 5. timeout: never ack
    snap();
    drive(1, 1, 0, 1, 32'h400, 32'h0, 5'd8);
    step(16);
    @(negedge clk);
    chk("tmo.last_wait_stall", 32'(bus.stall),   0);
    chk("tmo.last_wait_req",   32'(bus.mem_req), 1);
    step(1);
    drive(1, 0, 0, 0, 32'h55, 32'h0, 5'd7);
    @(negedge clk);
    chk("tmo.err",        32'(bus.err),     1);
    chk("tmo.req_after",  32'(bus.mem_req), 0);
    chk("tmo.req_cycles", 32'(req_cnt - r0), 16);
    chk("tmo.stall_cycles", 32'(stall_cnt - s0), 16);
    step(1);
    idle_ex();
    @(negedge clk);
    chk("tmo.next_alu_wbv",  32'(bus.wb_valid), 1);
    chk("tmo.next_alu_data", bus.wb_data,       32'h55);
    step(1);

    // 6. reset in WAIT, then a stray ack in IDLE
    drive(1, 1, 0, 1, 32'h500, 32'h0, 5'd9);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0; idle_ex();
    @(negedge clk);
    chk("rstwait.mem_req", 32'(bus.mem_req), 0);
    chk("rstwait.stall",   32'(bus.stall),   0);
    snap();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    step(1);
    bus.mem_ack = 1'b0;
    step(2);
    chk("stray_ack.wb_pulses", 32'(wbv_cnt - v0), 0);

    // 7. back-to-back: load acked immediately, then ALU op with no bubble
    drive(1, 1, 0, 0, 32'h600, 32'h0, 5'd10);
    step(1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11112222;
    step(1);
    bus.mem_ack = 1'b0;
    drive(1, 0, 0, 0, 32'h77, 32'h0, 5'd11);
    @(negedge clk);
    chk("b2b.load_data",     bus.wb_data,          32'h11112222);
    chk("b2b.load_memtoreg", 32'(bus.wb_memtoreg), 0);
    step(1);
    idle_ex();
    @(negedge clk);
    chk("b2b.alu_wbv",  32'(bus.wb_valid), 1);
    chk("b2b.alu_data", bus.wb_data,       32'h77);
    chk("b2b.alu_rd",   32'(bus.wb_rd),    11);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
